// File: rtl/uart_tx_if.sv
// Handshake and line bundle between a word source and uart_tx.
// The source drives the enable, valid and data signals; uart_tx drives the rest.
interface uart_tx_if #(
  parameter int PAYLOAD_BITS = 8
) ();
  logic                    uart_tx_en;
  logic                    uart_tx_valid;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;
  logic                    uart_tx_ready;
  logic                    uart_tx_busy;
  logic                    uart_txd;

  modport master (
    output uart_tx_en,
    output uart_tx_valid,
    output uart_tx_data,
    input  uart_tx_ready,
    input  uart_tx_busy,
    input  uart_txd
  );

  modport slave (
    input  uart_tx_en,
    input  uart_tx_valid,
    input  uart_tx_data,
    output uart_tx_ready,
    output uart_tx_busy,
    output uart_txd
  );
endinterface

// File: rtl/uart_tx.sv
// Buffered UART transmitter: FIFO of words feeding a start/data/stop framer.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input logic      clk,
  input logic      reset,
  uart_tx_if.slave bus
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = 1 + $clog2(CPB);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = PW + 1;
  localparam int BMX = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
  localparam int BW  = $clog2(BMX) + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e                  state_q, state_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] sh_q, sh_d;
  logic                    txd_q, txd_d;
  logic [NW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           rd_q, rd_d;
  logic [PW-1:0]           wr_q, wr_d;
  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic                    par_q, par_d;
`endif

  logic ready, push, pop, bit_end, start_ok, line;

  assign ready    = (cnt_q < NW'(FIFO_DEPTH));
  assign push     = bus.uart_tx_valid && ready;
  assign bit_end  = (cyc_q == CW'(CPB - 1));
  assign start_ok = (cnt_q != '0) && bus.uart_tx_en;

  assign bus.uart_tx_ready = ready;
  assign bus.uart_tx_busy  = (state_q != IDLE) || (cnt_q != '0);
  assign bus.uart_txd      = txd_q;

  // The line is registered from the state, so txd trails the state by one cycle.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    line    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (start_ok) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        line  = 1'b0;
        cyc_d = cyc_q + 1'b1;
        if (bit_end) begin
          cyc_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        line  = sh_q[0];
        cyc_d = cyc_q + 1'b1;
        if (bit_end) begin
          cyc_d = '0;
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(PAYLOAD_BITS - 1)) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line  = par_q;
        cyc_d = cyc_q + 1'b1;
        if (bit_end) begin
          cyc_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        line  = 1'b1;
        cyc_d = cyc_q + 1'b1;
        if (bit_end) begin
          cyc_d = '0;
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (start_ok) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      sh_d = mem_q[rd_q];
`ifdef UART_TX_PARITY_EN
      par_d = ^mem_q[rd_q];
`endif
    end
    txd_d = line;

    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.uart_tx_data;
  end
endmodule
